// File: rtl/fifo_stream_reader.sv
// Converts the registered-q FIFO read port into a valid/ready stream via a 3-entry skid buffer.
// Optional packet framing (m_last) is enabled by defining FIFO_STREAM_LAST_EN.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_STREAM_LAST_EN
  ,
  output logic             m_last
`endif
);

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_stream_reader: PKT_LEN must be >= 1");
  end

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    case (p)
      2'd0:    ptr_inc = 2'd1;
      2'd1:    ptr_inc = 2'd2;
      default: ptr_inc = 2'd0;
    endcase
  endfunction

  logic [WIDTH-1:0] buf_mem_q [0:2];
  logic [WIDTH-1:0] buf_mem_d [0:2];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_d;
  logic [2:0]       credit_s;
  logic             fire_s;

  // Pop only while buffered plus in-flight words leave a free slot.
  always_comb begin
    credit_s = {1'b0, occ_q} + {2'b00, infl_q};
    fifo_pop = rst & run & ~fifo_empty & (credit_s < 3'd3);
    m_valid  = rst & (occ_q != 2'd0);
    m_data   = buf_mem_q[rd_ptr_q];
    fire_s   = m_valid & m_ready;
  end

  // Next-state for buffer, pointers and occupancy.
  always_comb begin
    buf_mem_d = buf_mem_q;
    infl_d    = fifo_pop;
    if (infl_q) begin
      buf_mem_d[wr_ptr_q] = fifo_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fire_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, infl_q} - {1'b0, fire_s};
  end

  // Control state; an in-flight word is dropped by clearing infl on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
      infl_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
    end
  end

  // Data storage needs no reset: entries are only read once occ covers them.
  always_ff @(posedge clk) begin
    buf_mem_q <= buf_mem_d;
  end

`ifdef FIFO_STREAM_LAST_EN
  localparam int CW = $clog2(PKT_LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

  logic [CW-1:0] wcnt_q, wcnt_d;

  // Word-in-packet counter advances on each accepted word.
  always_comb begin
    m_last = m_valid & (wcnt_q == LAST_IDX);
    if (fire_s) begin
      wcnt_d = (wcnt_q == LAST_IDX) ? {CW{1'b0}} : wcnt_q + CW'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q <= {CW{1'b0}};
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-q FIFO model.
// Exercises FIFO_STREAM_LAST_EN framing when that macro is defined.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       fifo_empty;
  logic [7:0] fifo_q;
  logic       fifo_pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  logic [7:0] mem [0:2047];
  int         head = 0;
  int         tail = 0;
  int         errors = 0;
  int         checks = 0;

  int         rx_idx = 0;
  int         outst = 0;
  int         fire_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);

  always @(posedge clk) begin
    if (fifo_pop) begin
      fifo_q <= mem[head];
      head   <= head + 1;
    end
  end

`ifdef FIFO_STREAM_LAST_EN
  logic       m_last;
  logic       pop1;
  logic       m_valid1;
  logic [7:0] m_data1;
  logic       m_last1;

  fifo_stream_reader #(.WIDTH(8), .PKT_LEN(4)) dut (
    .clk(clk), .rst(rst), .run(run), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  fifo_stream_reader #(.WIDTH(8), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_pop(pop1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1)
  );
`else
  fifo_stream_reader #(.WIDTH(8), .PKT_LEN(4)) dut (
    .clk(clk), .rst(rst), .run(run), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[tail] = v;
    tail = tail + 1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && rx_idx != tail; i++) tick();
    check(tag, 32'(rx_idx), 32'(tail));
  endtask

  // Scoreboard: order, hold-while-stalled, credit bound and packet framing.
  always @(negedge clk) begin
    if (!rst) begin
      rx_idx     = head;
      outst      = 0;
      fire_cnt   = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        check("order", 32'(m_data), 32'(mem[rx_idx]));
`ifdef FIFO_STREAM_LAST_EN
        check("last4", 32'(m_last), 32'((fire_cnt % 4) == 3));
        check("last1", 32'(m_last1), 32'd1);
`endif
        rx_idx   = rx_idx + 1;
        fire_cnt = fire_cnt + 1;
      end
`ifdef FIFO_STREAM_LAST_EN
      else if (!m_valid) begin
        check("last_idle", 32'(m_last), 32'd0);
      end
      check("pop_match", 32'(pop1), 32'(fifo_pop));
`endif
      outst = outst + int'(fifo_pop) - int'(m_valid && m_ready);
      check("credit", 32'(outst <= 3), 32'd1);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    int npop;
    int base;
    rst = 1'b0; run = 1'b0; m_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    for (int i = 1; i <= 10; i++) push(8'(i));
    #1;
    check("rst_pop", 32'(fifo_pop), 32'd0);

    // Stream of 0x01..0x0A at full rate.
    tick();
    rst = 1'b1; run = 1'b1; m_ready = 1'b1;
    #1;
    check("first_pop", 32'(fifo_pop), 32'd1);
    tick(); #1;
    check("lat_c1_valid", 32'(m_valid), 32'd0);
    for (int k = 2; k <= 11; k++) begin
      tick(); #1;
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_data", 32'(m_data), 32'(k - 1));
    end
    tick(); #1;
    check("stream_end", 32'(m_valid), 32'd0);
    check("stream_cnt", 32'(rx_idx), 32'd10);

    // Backpressure: exactly three pops then stop.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (fifo_pop) npop++;
      tick();
    end
    #1;
    check("bp_pops", 32'(npop), 32'd3);
    check("bp_pop_now", 32'(fifo_pop), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'h20);
    m_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Random ready over 1000 random words.
    for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 6000 && rx_idx != tail; i++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
    end
    check("rand_drain", 32'(rx_idx), 32'(tail));

    // Empty FIFO and run gating.
    tick();
    m_ready = 1'b1;
    #1;
    check("empty_pop", 32'(fifo_pop), 32'd0);
    run = 1'b0;
    push(8'h50); push(8'h51); push(8'h52);
    #1;
    check("run0_pop", 32'(fifo_pop), 32'd0);
    tick();
    run = 1'b1;
    base = head;
    #1;
    check("run1_pop", 32'(fifo_pop), 32'd1);
    tick();
    run = 1'b0;
    #1;
    check("run_drop_pop", 32'(fifo_pop), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      check("run_off_pop", 32'(fifo_pop), 32'd0);
    end
    check("run_infl_out", 32'(rx_idx), 32'(base + 1));
    check("run_head", 32'(head), 32'(base + 1));
    run = 1'b1;
    wait_drain("run_drain", 20);

    // Reset with occ=2 and one word in flight.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    base = head;
    repeat (3) tick();
    #1;
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_pop", 32'(fifo_pop), 32'd0);
    rst = 1'b0;
    #1;
    check("in_rst_valid", 32'(m_valid), 32'd0);
    check("in_rst_pop", 32'(fifo_pop), 32'd0);
    tick(); #1;
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_pop", 32'(fifo_pop), 32'd0);
    check("rst_head", 32'(head), 32'(base + 3));
    tick();
    rst = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    #1;
    check("resume_data", 32'(m_data), 32'h63);
    wait_drain("rst_drain", 20);

`ifdef FIFO_STREAM_LAST_EN
    // Packet framing over 12 words from a fresh reset.
    tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 12; i++) push(8'(8'h80 + i));
    rst = 1'b1;
    wait_drain("pkt_drain", 40);
    check("pkt_fires", 32'(fire_cnt), 32'd12);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
